// File: rtl/scan_sequencer3.sv
// scan_sequencer3 -- channel scan sequencer driving a 3-to-8 decoder.
// Steps through the enabled channels of a live mask, holding each for
// (dwell + 1) cycles, in continuous or single-pass mode.
// Optional feature macro: SCAN_BLANK_EN inserts one blanking cycle
// (sel_en=0, sel already updated) at every channel advance.
module scan_sequencer3 #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         mask,
  output logic [2:0]         sel,
  output logic               sel_en,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef SCAN_BLANK_EN
    BLANK = 2'd2,
`endif
    SCAN  = 2'd1
  } state_t;

  state_t             state_q;
  logic [2:0]         sel_q;
  logic               sel_en_q;
  logic               busy_q;
  logic               wrap_q;
  logic               done_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               oneshot_q;
  logic [DWELL_W-1:0] cnt_q;

  logic [2:0]         low_sel_d;
  logic [2:0]         adv_sel_d;
  logic               adv_wrap_d;
  logic               dwell_done_d;

  // Lowest set bit of the live mask: first channel of a new scan.
  always_comb begin
    low_sel_d = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) low_sel_d = 3'(i);
    end
  end

  // Next set mask bit strictly after sel, searching cyclically; an offset
  // of 8 lands back on sel itself so a lone set bit reselects it.
  always_comb begin
    logic [2:0] idx;
    idx       = 3'd0;
    adv_sel_d = sel_q;
    for (int k = 8; k >= 1; k--) begin
      idx = sel_q + 3'(k);
      if (mask[idx]) adv_sel_d = idx;
    end
  end

  // A move to a lower or equal index means the pass has wrapped.
  always_comb begin
    adv_wrap_d   = (adv_sel_d <= sel_q);
    dwell_done_d = (cnt_q == dwell_q);
  end

  // Sequencer FSM with all outputs registered; pulses default low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 3'd0;
      sel_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      dwell_q   <= '0;
      oneshot_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop && (mask != 8'h00)) begin
            state_q   <= SCAN;
            sel_q     <= low_sel_d;
            sel_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            dwell_q   <= dwell;
            oneshot_q <= oneshot;
          end
        end
        SCAN: begin
          if (stop) begin
            state_q  <= IDLE;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (dwell_done_d) begin
            if (mask == 8'h00) begin
              // Nothing left to scan: drop out quietly.
              state_q  <= IDLE;
              sel_en_q <= 1'b0;
              busy_q   <= 1'b0;
            end else if (oneshot_q && adv_wrap_d) begin
              // Single pass complete: sel keeps the last channel.
              state_q  <= IDLE;
              sel_en_q <= 1'b0;
              busy_q   <= 1'b0;
              wrap_q   <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              sel_q  <= adv_sel_d;
              wrap_q <= adv_wrap_d;
              cnt_q  <= '0;
`ifdef SCAN_BLANK_EN
              state_q  <= BLANK;
              sel_en_q <= 1'b0;
`endif
            end
          end else begin
            cnt_q <= cnt_q + DWELL_W'(1);
          end
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          if (stop) begin
            state_q  <= IDLE;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            state_q  <= SCAN;
            sel_en_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q  <= IDLE;
          sel_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sel    = sel_q;
  assign sel_en = sel_en_q;
  assign busy   = busy_q;
  assign wrap   = wrap_q;
  assign done   = done_q;

endmodule

// File: tb/tb_scan_sequencer3.sv
// Testbench for scan_sequencer3: directed vector table, a hand-written
// continuous-scan sequence, then randomized stimulus against a
// behavioural channel-scan model.
`timescale 1ns/1ps
module tb_scan_sequencer3;

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0, stop = 1'b0, oneshot = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic [7:0] mask = 8'd0;
  logic [2:0] sel;
  logic       sel_en, busy, wrap, done;

  int n_vec  = 0;
  int n_miss = 0;

  scan_sequencer3 #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot),
    .dwell(dwell), .mask(mask), .sel(sel), .sel_en(sel_en), .busy(busy),
    .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, start, stop, oneshot;
    logic [7:0] dwell, mask;
    logic [2:0] e_sel;
    logic       e_en, e_busy, e_wrap, e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic r, logic s, logic p, logic o,
                              logic [7:0] d, logic [7:0] m, logic [2:0] es,
                              logic ee, logic eb, logic ew, logic ed);
    vec_t v;
    v.name = name; v.rst = r; v.start = s; v.stop = p; v.oneshot = o;
    v.dwell = d; v.mask = m; v.e_sel = es; v.e_en = ee; v.e_busy = eb;
    v.e_wrap = ew; v.e_done = ed;
    return v;
  endfunction

  task automatic check(string name, logic [2:0] es, logic ee, logic eb,
                       logic ew, logic ed);
    n_vec++;
    if (sel !== es || sel_en !== ee || busy !== eb || wrap !== ew || done !== ed) begin
      n_miss++;
      $display("FAIL %s: got sel=%0d en=%b busy=%b wrap=%b done=%b, want sel=%0d en=%b busy=%b wrap=%b done=%b",
               name, sel, sel_en, busy, wrap, done, es, ee, eb, ew, ed);
    end
  endtask

  task automatic drive(logic r, logic s, logic p, logic o, logic [7:0] d, logic [7:0] m);
    rst = r; start = s; stop = p; oneshot = o; dwell = d; mask = m;
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks whether a scan is active, the current channel and how many
  // enabled cycles it has already received.
  logic       m_active, m_blank, m_one, m_wrap, m_done;
  int         m_sel, m_spent, m_hold;

  function automatic int lowest(logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_after(logic [7:0] m, int cur);
    for (int k = 1; k <= 8; k++) if (m[(cur + k) % 8]) return (cur + k) % 8;
    return cur;
  endfunction

  task automatic model_step();
    int n;
    m_wrap = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_active = 0; m_blank = 0; m_sel = 0; m_spent = 0; m_hold = 1; m_one = 0;
    end else if (!m_active) begin
      if (start && !stop && mask != 8'h00) begin
        m_active = 1; m_blank = 0; m_sel = lowest(mask);
        m_hold = int'(dwell) + 1; m_one = oneshot; m_spent = 1;
      end
    end else if (stop) begin
      m_active = 0; m_blank = 0;
    end else if (m_blank) begin
      m_blank = 0; m_spent = 1;
    end else if (m_spent < m_hold) begin
      m_spent++;
    end else if (mask == 8'h00) begin
      m_active = 0;
    end else begin
      n = next_after(mask, m_sel);
      if (m_one && n <= m_sel) begin
        m_active = 0; m_done = 1; m_wrap = 1;
      end else begin
        m_wrap = (n <= m_sel);
        m_sel = n;
        m_spent = 1;
`ifdef SCAN_BLANK_EN
        m_blank = 1;
`endif
      end
    end
  endtask

  initial begin
    // Directed table (timing written for the default build).
    tbl.push_back(mk("reset",      1,0,0,0, 8'd0, 8'h00, 3'd0, 0,0,0,0));
`ifndef SCAN_BLANK_EN
    tbl.push_back(mk("os_start",   0,1,0,1, 8'd1, 8'h03, 3'd0, 1,1,0,0));
    tbl.push_back(mk("os_ch0_b",   0,0,0,0, 8'd0, 8'h03, 3'd0, 1,1,0,0));
    tbl.push_back(mk("os_ch1_a",   0,0,0,0, 8'd0, 8'h03, 3'd1, 1,1,0,0));
    tbl.push_back(mk("os_ch1_b",   0,0,0,0, 8'd0, 8'h03, 3'd1, 1,1,0,0));
    tbl.push_back(mk("os_done",    0,0,0,0, 8'd0, 8'h03, 3'd1, 0,0,1,1));
    tbl.push_back(mk("os_idle",    0,0,0,0, 8'd0, 8'h03, 3'd1, 0,0,0,0));
    tbl.push_back(mk("st_start",   0,1,0,0, 8'd5, 8'h08, 3'd3, 1,1,0,0));
    tbl.push_back(mk("st_stop",    0,0,1,0, 8'd5, 8'h08, 3'd3, 0,0,0,0));
    tbl.push_back(mk("st_mask0",   0,1,0,0, 8'd5, 8'h00, 3'd3, 0,0,0,0));
    tbl.push_back(mk("st_startstop",0,1,1,0,8'd5, 8'hFF, 3'd3, 0,0,0,0));
    tbl.push_back(mk("sp_start",   0,1,0,0, 8'd0, 8'hA4, 3'd2, 1,1,0,0));
    tbl.push_back(mk("sp_ch5",     0,1,0,0, 8'd5, 8'hA4, 3'd5, 1,1,0,0));
    tbl.push_back(mk("sp_ch7",     0,0,0,0, 8'd0, 8'hA4, 3'd7, 1,1,0,0));
    tbl.push_back(mk("sp_wrap",    0,0,0,0, 8'd0, 8'hA4, 3'd2, 1,1,1,0));
    tbl.push_back(mk("sp_mask0",   0,0,0,0, 8'd0, 8'h00, 3'd2, 0,0,0,0));
    tbl.push_back(mk("rs_start",   0,1,0,0, 8'd3, 8'hFF, 3'd0, 1,1,0,0));
    tbl.push_back(mk("rs_reset",   1,0,0,0, 8'd3, 8'hFF, 3'd0, 0,0,0,0));
`else
    tbl.push_back(mk("bl_start",   0,1,0,0, 8'd1, 8'h81, 3'd0, 1,1,0,0));
    tbl.push_back(mk("bl_ch0_b",   0,0,0,0, 8'd1, 8'h81, 3'd0, 1,1,0,0));
    tbl.push_back(mk("bl_blank7",  0,0,0,0, 8'd1, 8'h81, 3'd7, 0,1,0,0));
    tbl.push_back(mk("bl_ch7_a",   0,0,0,0, 8'd1, 8'h81, 3'd7, 1,1,0,0));
    tbl.push_back(mk("bl_ch7_b",   0,0,0,0, 8'd1, 8'h81, 3'd7, 1,1,0,0));
    tbl.push_back(mk("bl_blank0",  0,0,0,0, 8'd1, 8'h81, 3'd0, 0,1,1,0));
    tbl.push_back(mk("bl_ch0_a",   0,0,0,0, 8'd1, 8'h81, 3'd0, 1,1,0,0));
    tbl.push_back(mk("bl_stop",    0,0,1,0, 8'd1, 8'h81, 3'd0, 0,0,0,0));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].oneshot, tbl[i].dwell, tbl[i].mask);
      @(posedge clk); #1;
      check(tbl[i].name, tbl[i].e_sel, tbl[i].e_en, tbl[i].e_busy, tbl[i].e_wrap, tbl[i].e_done);
    end

`ifndef SCAN_BLANK_EN
    // Continuous full-mask scan, dwell=2: 3 cycles per channel, wrap at t=24.
    drive(1,0,0,0, 8'd0, 8'hFF); @(posedge clk); #1;
    drive(0,1,0,0, 8'd2, 8'hFF);
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      drive(0,0,0,0, 8'd0, 8'hFF);
      check($sformatf("full_t%0d", t), 3'((t / 3) % 8), 1'b1, 1'b1, (t == 24), 1'b0);
    end
`endif

    // Randomized phase against the behavioural model.
    for (int c = 0; c < 4000; c++) begin
      logic [7:0] nm;
      nm = mask;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: nm = 8'h00;
          1: nm = 8'(1 << $urandom_range(0, 7));
          default: nm = 8'($urandom);
        endcase
      end
      drive((c == 0) || ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 24) == 0),
            1'($urandom),
            8'($urandom_range(0, 3)),
            nm);
      model_step();
      @(posedge clk); #1;
      check($sformatf("rand_c%0d", c), 3'(m_sel), m_active && !m_blank,
            m_active, m_wrap, m_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/scan_sequencer3.md
SCAN_SEQUENCER3 -- requirements
Module: scan_sequencer3

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the dwell count input.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  begin scanning; sampled only in IDLE.
REQ-005 Port: stop  input  1  abort scanning; sampled in every state.
REQ-006 Port: oneshot  input  1  sampled with start; 1 = single pass, 0 = continuous.
REQ-007 Port: dwell  input  DWELL_W  per-channel hold count; latched on accepted start.
REQ-008 Port: mask  input  8  channel enable bits; bit i = 1 means channel i is scanned; read live at every advance.
REQ-009 Port: sel  output  3  registered channel index; drives the downstream 3-to-8 decoder's index input.
REQ-010 Port: sel_en  output  1  registered enable; drives the decoder's enable input.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: wrap  output  1  one-cycle pulse when the scan wraps to a lower or equal index.
REQ-013 Port: done  output  1  one-cycle pulse when a oneshot pass completes.

Function
REQ-014 The block SHALL implement an FSM with states IDLE and SCAN, plus BLANK when SCAN_BLANK_EN is defined.
REQ-015 In IDLE, start=1, stop=0 and mask!=0 SHALL cause a transition to SCAN on the next edge, with sel = lowest set bit of mask, sel_en=1, and dwell and oneshot latched.
REQ-016 A start in IDLE with mask==0, or with stop=1 in the same cycle, SHALL be ignored; the block stays in IDLE.
REQ-017 A start while busy=1 SHALL be ignored.
REQ-018 Each channel SHALL be held with sel_en=1 for exactly dwell_latched+1 cycles; dwell=0 gives 1 cycle.
REQ-019 Advance SHALL select the next set mask bit above sel in ascending order, wrapping from 7 to 0; a single set bit reselects the same channel.
REQ-020 The advance that yields an index <= the current sel SHALL pulse wrap for one cycle, aligned with the first cycle sel shows the new index.
REQ-021 If mask==0 at an advance, the block SHALL go to IDLE: sel_en=0, sel held, no wrap pulse.
REQ-022 With oneshot latched as 1, the wrapping advance SHALL instead go to IDLE: done and wrap pulse together, sel_en=0, sel held.
REQ-023 stop=1 in SCAN or BLANK SHALL force IDLE on the next edge: sel_en=0, busy=0, sel held, no wrap or done pulse; stop takes priority over an advance in the same cycle.
REQ-024 Latency SHALL be one cycle from start sampled to sel_en=1; all outputs are registered.
REQ-025 sel_en SHALL be 0 whenever busy=0.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL enter IDLE with sel=0, sel_en=0, busy=0, wrap=0, done=0, and latched dwell and oneshot cleared.
REQ-027 rst SHALL take priority over start and stop; reset mid-scan aborts with no wrap or done pulse.

Configuration
REQ-028 Macro SCAN_BLANK_EN defined: every advance, including reselecting the same channel, SHALL pass through one BLANK cycle with sel already updated and sel_en=0 before returning to SCAN; wrap aligns with the BLANK cycle.
REQ-029 Macro SCAN_BLANK_EN undefined: BLANK SHALL not exist, and advances go SCAN to SCAN with sel_en held at 1.

Verification
REQ-030 No macro, mask=8'hFF, dwell=2, oneshot=0, start pulse -> sel steps 0..7 at 3 cycles each, sel_en=1 throughout, wrap pulses when sel returns to 0 (24 cycles after the first sel_en=1), and the sequence repeats.
REQ-031 No macro, mask=8'b1010_0100, dwell=0 -> sel 2,5,7,2,5,7,..., one cycle each; wrap pulses on each 7->2 transition.
REQ-032 oneshot=1, mask=8'h03, dwell=1 -> sel 0 for 2 cycles, then 1 for 2 cycles, then done=wrap=1 for one cycle, busy=0, sel_en=0, sel=1.
REQ-033 stop during channel 3 -> next cycle sel_en=0, busy=0, sel=3; a start with mask=0 -> busy stays 0; rst mid-scan -> all outputs 0 on the next cycle.
REQ-034 SCAN_BLANK_EN defined, mask=8'h81, dwell=1 -> sel 0 (en 2 cycles), 7 (en 0, 1 cycle), 7 (en 2 cycles), 0 (en 0, 1 cycle, wrap=1), repeating.
REQ-035 A mask changed to 8'h00 mid-dwell -> IDLE at the next advance with no wrap pulse.
